// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arbiter
// Purpose  : Round-robin share of one APB4 master port between two requesters,
//            with alignment/window checks. Optional ACCESS timeout: APB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module apb_master_arbiter #(
    parameter int                 APB_AW    = 32,
    parameter int                 APB_DW    = 32,
    parameter logic [APB_AW-1:0]  PERIPH_BA = '0,
    parameter logic [APB_AW-1:0]  WIN_BYTES = APB_AW'('h1040)
`ifdef APB_TIMEOUT_EN
    ,
    parameter int                 TIMEOUT   = 16
`endif
) (
    input  logic                      pclk,
    input  logic                      prst,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_write,
    input  logic [2*APB_AW-1:0]       req_addr,
    input  logic [2*APB_DW-1:0]       req_wdata,
    input  logic [2*(APB_DW/8)-1:0]   req_strb,
    output logic [1:0]                req_ready,
    output logic [1:0]                rsp_valid,
    output logic [APB_DW-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_AW-1:0]         PADDR,
    output logic [APB_DW-1:0]         PWDATA,
    output logic [APB_DW/8-1:0]       PSTRB,
    input  logic [APB_DW-1:0]         PRDATA,
    input  logic                      PREADY
);

    localparam int PSTRB_W = APB_DW / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t               state_q,      state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 grant_q,      grant_d;
    logic                 psel_q,       psel_d;
    logic                 penable_q,    penable_d;
    logic                 pwrite_q,     pwrite_d;
    logic [APB_AW-1:0]    paddr_q,      paddr_d;
    logic [APB_DW-1:0]    pwdata_q,     pwdata_d;
    logic [PSTRB_W-1:0]   pstrb_q,      pstrb_d;
    logic [1:0]           rsp_valid_q,  rsp_valid_d;
    logic [APB_DW-1:0]    rsp_rdata_q,  rsp_rdata_d;
    logic                 rsp_err_q,    rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0]           cnt_q, cnt_d;
`endif

    logic                 w_any;
    logic                 w_gnt;
    logic                 w_sel_write;
    logic [APB_AW-1:0]    w_sel_addr;
    logic [APB_DW-1:0]    w_sel_wdata;
    logic [PSTRB_W-1:0]   w_sel_strb;
    logic [APB_AW:0]      w_off;
    logic                 w_chk_err;

    // On a tie the requester that did not win last time is served.
    assign w_any       = |req_valid;
    assign w_gnt       = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    assign w_sel_write = w_gnt ? req_write[1] : req_write[0];
    assign w_sel_addr  = w_gnt ? req_addr[2*APB_AW-1:APB_AW]     : req_addr[APB_AW-1:0];
    assign w_sel_wdata = w_gnt ? req_wdata[2*APB_DW-1:APB_DW]    : req_wdata[APB_DW-1:0];
    assign w_sel_strb  = w_gnt ? req_strb[2*PSTRB_W-1:PSTRB_W]   : req_strb[PSTRB_W-1:0];

    // Extra MSB of the offset is the borrow, i.e. address below the window base.
    assign w_off     = {1'b0, w_sel_addr} - {1'b0, PERIPH_BA};
    assign w_chk_err = (w_sel_addr[1:0] != 2'b00) || w_off[APB_AW]
                    || (w_off[APB_AW-1:0] >= WIN_BYTES);

    assign req_ready = (!prst && state_q == S_IDLE && w_any) ? (2'b01 << w_gnt) : 2'b00;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        rsp_valid_d  = 2'b00;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
`ifdef APB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    grant_d      = w_gnt;
                    last_grant_d = w_gnt;
                    if (w_chk_err) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 2'b01 << w_gnt;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = S_SETUP;
                        psel_d   = 1'b1;
                        pwrite_d = w_sel_write;
                        paddr_d  = w_sel_addr;
                        pwdata_d = w_sel_wdata;
                        pstrb_d  = w_sel_write ? w_sel_strb : '0;
                    end
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            S_ACCESS: begin
                if (PREADY) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 2'b01 << grant_q;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pwrite_d    = 1'b0;
                    paddr_d     = '0;
                    pwdata_d    = '0;
                    pstrb_d     = '0;
`ifdef APB_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 2'b01 << grant_q;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pwrite_d    = 1'b0;
                    paddr_d     = '0;
                    pwdata_d    = '0;
                    pstrb_d     = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_arbiter
// Purpose  : Directed scoreboard bench for apb_master_arbiter (APB_TIMEOUT_EN aware).
// Revision : 1.0
// ============================================================================
module tb_apb_master_arbiter;

    logic        pclk;
    logic        prst;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        req;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    apb_master_arbiter dut (
        .pclk      (pclk),
        .prst      (prst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] s);
        req_write[i]          = wr;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = wd;
        req_strb[i*4 +: 4]    = s;
    endtask

    task automatic push(input logic r, input logic [31:0] d, input logic e);
        exp_t x;
        x.req   = r;
        x.rdata = d;
        x.err   = e;
        sb.push_back(x);
    endtask

    // Pops the oldest expectation and compares it against the response now on the bus.
    task automatic sb_check(input string tag);
        exp_t x;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s_sb observed=unexpected_rsp expected=no_rsp", tag);
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check({tag, "_rsp_valid"}, rsp_valid, 2'b01 << x.req);
            check({tag, "_rsp_rdata"}, rsp_rdata, x.rdata);
            check({tag, "_rsp_err"},   rsp_err,   x.err);
        end
    endtask

    // Single request on an otherwise idle arbiter, slave inserting `waits` wait states.
    task automatic run_txn(input string tag, input int idx, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] s, input int waits,
                           input logic [31:0] prd, input logic exp_err);
        int cyc;
        int w;
        set_req(idx, wr, a, wd, s);
        req_valid = 2'b01 << idx;
        PREADY    = (waits == 0);
        PRDATA    = prd;
        #1;
        cyc = 0;
        while (req_ready != (2'b01 << idx) && cyc < 10) begin
            tick();
            cyc++;
        end
        check({tag, "_ready"}, req_ready, 2'b01 << idx);
        push(idx[0], (wr || exp_err) ? 32'h0 : prd, exp_err);
        tick();
        req_valid = 2'b00;
        w   = 0;
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < 80) begin
            if (PSEL && PENABLE) begin
                if (w == 0) check({tag, "_pstrb"}, PSTRB, wr ? s : 4'h0);
                PREADY = (w == waits);
                w++;
            end
            tick();
            cyc++;
        end
        sb_check(tag);
        check({tag, "_psel_idle"}, PSEL, 1'b0);
        PREADY = 1'b0;
    endtask

    initial begin
        int n;
        int cyc;
        int last_acc;
        int acc;
        logic [1:0] eg;

        prst      = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        tick();
        tick();
        req_valid = 2'b11;
        #1;
        check("rst_ready",     req_ready, 2'b00);
        check("rst_psel",      PSEL,      1'b0);
        check("rst_penable",   PENABLE,   1'b0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_paddr",     PADDR,     32'h0);
        req_valid = 2'b00;
        prst      = 1'b0;
        tick();

        // 1: zero-wait write from requester 0
        set_req(0, 1'b1, 32'h4, 32'hFF, 4'hF);
        req_valid = 2'b01;
        PREADY    = 1'b1;
        #1;
        check("t1_ready", req_ready, 2'b01);
        push(1'b0, 32'h0, 1'b0);
        tick();
        req_valid = 2'b00;
        check("t1_setup_psel",    PSEL,    1'b1);
        check("t1_setup_penable", PENABLE, 1'b0);
        check("t1_setup_paddr",   PADDR,   32'h4);
        check("t1_setup_pwdata",  PWDATA,  32'hFF);
        check("t1_setup_pstrb",   PSTRB,   4'hF);
        check("t1_setup_pwrite",  PWRITE,  1'b1);
        check("t1_setup_rsp",     rsp_valid, 2'b00);
        tick();
        check("t1_acc_psel",    PSEL,    1'b1);
        check("t1_acc_penable", PENABLE, 1'b1);
        check("t1_acc_paddr",   PADDR,   32'h4);
        check("t1_acc_pwdata",  PWDATA,  32'hFF);
        tick();
        sb_check("t1");
        check("t1_resp_psel",  PSEL,  1'b0);
        check("t1_resp_paddr", PADDR, 32'h0);
        tick();

        // 2: read from requester 1 with three wait states
        PREADY = 1'b0;
        set_req(1, 1'b0, 32'h100C, 32'hDEAD_BEEF, 4'hF);
        req_valid = 2'b10;
        #1;
        check("t2_ready", req_ready, 2'b10);
        push(1'b1, 32'h0012_3456, 1'b0);
        tick();
        req_valid = 2'b00;
        check("t2_setup_psel",  PSEL,   1'b1);
        check("t2_setup_pstrb", PSTRB,  4'h0);
        check("t2_setup_paddr", PADDR,  32'h100C);
        check("t2_setup_pwrite", PWRITE, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_acc_penable", PENABLE,   1'b1);
            check("t2_acc_pstrb",   PSTRB,     4'h0);
            check("t2_acc_norsp",   rsp_valid, 2'b00);
            if (k == 3) begin
                PREADY = 1'b1;
                PRDATA = 32'h0012_3456;
            end
        end
        tick();
        sb_check("t2");
        PREADY = 1'b0;
        tick();

        // 3: both requesters always valid -> strict alternation 0,1,0,1, accepts 4 cycles apart
        set_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h1000, 32'h5555_AAAA, 4'h3);
        PRDATA    = 32'hCAFE_0003;
        PREADY    = 1'b1;
        req_valid = 2'b11;
        #1;
        n        = 0;
        cyc      = 0;
        last_acc = -1;
        while (n < 4 && cyc < 40) begin
            if (rsp_valid != 2'b00) sb_check("t3");
            if (req_ready != 2'b00) begin
                eg = (n % 2 == 0) ? 2'b01 : 2'b10;
                check("t3_grant", req_ready, eg);
                if (n > 0) check("t3_spacing", cyc - last_acc, 4);
                push(eg[1], eg[1] ? 32'h0 : 32'hCAFE_0003, 1'b0);
                last_acc = cyc;
                n++;
            end
            tick();
            cyc++;
        end
        check("t3_accepts", n, 4);
        req_valid = 2'b00;
        cyc = 0;
        while (sb.size() != 0 && cyc < 10) begin
            if (rsp_valid != 2'b00) sb_check("t3");
            tick();
            cyc++;
        end
        check("t3_drained", sb.size(), 0);
        PREADY = 1'b0;
        tick();

        // 4: check errors - just past the window, then misaligned; both answer one cycle after accept
        PRDATA = 32'hFFFF_FFFF;
        set_req(0, 1'b0, 32'h1040, 32'h0, 4'h0);
        req_valid = 2'b01;
        #1;
        check("t4a_ready", req_ready, 2'b01);
        push(1'b0, 32'h0, 1'b1);
        tick();
        req_valid = 2'b00;
        check("t4a_psel", PSEL, 1'b0);
        sb_check("t4a");
        tick();
        set_req(0, 1'b0, 32'h2, 32'h0, 4'h0);
        req_valid = 2'b01;
        #1;
        check("t4b_ready", req_ready, 2'b01);
        push(1'b0, 32'h0, 1'b1);
        tick();
        req_valid = 2'b00;
        check("t4b_psel", PSEL, 1'b0);
        sb_check("t4b");
        tick();
        run_txn("t4c_last_word", 1, 1'b0, 32'h103C, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 1'b0);
        tick();

`ifdef APB_TIMEOUT_EN
        // 5: stuck slave is aborted after 16 ACCESS cycles
        set_req(0, 1'b0, 32'h8, 32'h0, 4'h0);
        req_valid = 2'b01;
        PREADY    = 1'b0;
        PRDATA    = 32'h1357_9BDF;
        #1;
        check("t5_ready", req_ready, 2'b01);
        push(1'b0, 32'h0, 1'b1);
        tick();
        req_valid = 2'b00;
        acc = 0;
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < 40) begin
            if (PSEL && PENABLE) acc++;
            tick();
            cyc++;
        end
        check("t5_access_cycles", acc, 16);
        sb_check("t5");
        check("t5_psel", PSEL, 1'b0);
        tick();
        run_txn("t5_next", 1, 1'b0, 32'h400, 32'h0, 4'h0, 2, 32'h2468_ACE0, 1'b0);
`else
        // 5: without the timeout a long-stalled slave still completes normally
        acc = 0;
        run_txn("t5_long_wait", 0, 1'b0, 32'h8, 32'h0, 4'h0, 20, 32'h1357_9BDF, 1'b0);
        run_txn("t5_next", 1, 1'b1, 32'h400, 32'h7777_0000, 4'hC, 1, 32'hFFFF_FFFF, 1'b0);
`endif
        tick();

        // 6: reset in ACCESS drops the bus, suppresses the response and re-arms req 0 priority
        set_req(0, 1'b1, 32'h10, 32'h1234, 4'hF);
        req_valid = 2'b01;
        PREADY    = 1'b0;
        #1;
        check("t6_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        check("t6_acc_penable", PENABLE, 1'b1);
        prst      = 1'b1;
        req_valid = 2'b11;
        set_req(1, 1'b0, 32'h104, 32'h0, 4'h0);
        tick();
        check("t6_rst_psel",    PSEL,      1'b0);
        check("t6_rst_penable", PENABLE,   1'b0);
        check("t6_rst_rsp",     rsp_valid, 2'b00);
        check("t6_rst_ready",   req_ready, 2'b00);
        tick();
        prst = 1'b0;
        #1;
        check("t6_post_grant", req_ready, 2'b01);
        push(1'b0, 32'h0, 1'b0);
        tick();
        req_valid = 2'b00;
        PREADY    = 1'b1;
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < 10) begin
            tick();
            cyc++;
        end
        sb_check("t6");
        PREADY = 1'b0;
        tick();
        check("t6_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
